regbank_p2_arbiter: RTL and testbench

//  Shares one RegBankP2 instruction port between two requesters.

---
 rtl/regbank_p2_arbiter.sv | 137 +++++++++++++
 tb/tb_regbank_p2_arbiter.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/regbank_p2_arbiter.sv
// Two-requester front end for the RegBankP2 instruction port: one-entry holds, arbiter, opcode screen.
// Define REGBANK_P2_ARBITER_LOCK_EN to let the last-granted requester hold the grant via reqN_lock.
`ifndef RegBankP2_NOP
`define RegBankP2_NOP 4'h0
`endif
`ifndef RegBankP2_LD0
`define RegBankP2_LD0 4'h1
`endif
`ifndef RegBankP2_LD1
`define RegBankP2_LD1 4'h2
`endif

module regbank_p2_arbiter #(
  parameter int OPCODE_W = 4,
  parameter int DATA_W   = 8,
  parameter bit PRIO_FIX = 1'b0
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [OPCODE_W+DATA_W-1:0] req0_inst,
  input  logic                       req0_valid,
  output logic                       req0_ready,
  input  logic                       req0_lock,
  input  logic [OPCODE_W+DATA_W-1:0] req1_inst,
  input  logic                       req1_valid,
  output logic                       req1_ready,
  input  logic                       req1_lock,
  output logic [OPCODE_W+DATA_W-1:0] inst,
  output logic                       inst_en,
  output logic                       grant,
  output logic                       error
);
  localparam int INST_W = OPCODE_W + DATA_W;

  typedef enum logic {LAST0 = 1'b0, LAST1 = 1'b1} last_e;

  last_e             state_r;
  logic [INST_W-1:0] hold0_r, hold1_r, inst_r, win_inst_s;
  logic              hold0_full_r, hold1_full_r, ready0_r, ready1_r;
  logic              inst_en_r, grant_r, error_r;
  logic              acc0_s, acc1_s, lock0_s, lock1_s;
  logic              win_valid_s, win_idx_s, full0_nx_s, full1_nx_s;

  function automatic logic opcode_legal(input logic [OPCODE_W-1:0] op);
    logic legal;
    case (op)
      `RegBankP2_NOP, `RegBankP2_LD0, `RegBankP2_LD1: legal = 1'b1;
      default:                                          legal = 1'b0;
    endcase
    return legal;
  endfunction

`ifdef REGBANK_P2_ARBITER_LOCK_EN
  assign lock0_s = req0_lock & (state_r == LAST0);
  assign lock1_s = req1_lock & (state_r == LAST1);
`else
  logic unused_lock_s;
  assign unused_lock_s = req0_lock ^ req1_lock;
  assign lock0_s       = 1'b0;
  assign lock1_s       = 1'b0;
`endif

  assign acc0_s = req0_valid & ready0_r;
  assign acc1_s = req1_valid & ready1_r;

  // Winner selection among full holds, plus next hold occupancy.
  always_comb begin
    win_valid_s = hold0_full_r | hold1_full_r;
    win_idx_s   = 1'b0;
    if (hold0_full_r && hold1_full_r) begin
      if (lock0_s) begin
        win_idx_s = 1'b0;
      end else if (lock1_s) begin
        win_idx_s = 1'b1;
      end else if (PRIO_FIX) begin
        win_idx_s = 1'b0;
      end else begin
        win_idx_s = (state_r == LAST0);
      end
    end else if (hold1_full_r) begin
      win_idx_s = 1'b1;
    end else begin
      win_idx_s = 1'b0;
    end
    win_inst_s = win_idx_s ? hold1_r : hold0_r;
    full0_nx_s = acc0_s | (hold0_full_r & ~(win_valid_s & ~win_idx_s));
    full1_nx_s = acc1_s | (hold1_full_r & ~(win_valid_s & win_idx_s));
  end

  // Holds, last-grant FSM and registered issue outputs.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r      <= LAST1;
      hold0_r      <= {INST_W{1'b0}};
      hold1_r      <= {INST_W{1'b0}};
      hold0_full_r <= 1'b0;
      hold1_full_r <= 1'b0;
      ready0_r     <= 1'b0;
      ready1_r     <= 1'b0;
      inst_r       <= {INST_W{1'b0}};
      inst_en_r    <= 1'b0;
      grant_r      <= 1'b0;
      error_r      <= 1'b0;
    end else begin
      if (acc0_s) hold0_r <= req0_inst;
      if (acc1_s) hold1_r <= req1_inst;
      hold0_full_r <= full0_nx_s;
      hold1_full_r <= full1_nx_s;
      ready0_r     <= ~full0_nx_s;
      ready1_r     <= ~full1_nx_s;
      if (win_valid_s) begin
        grant_r <= win_idx_s;
        state_r <= win_idx_s ? LAST1 : LAST0;
        // Illegal opcodes are dropped: inst keeps its old value, error pulses.
        if (opcode_legal(win_inst_s[INST_W-1:DATA_W])) begin
          inst_r    <= win_inst_s;
          inst_en_r <= 1'b1;
          error_r   <= 1'b0;
        end else begin
          inst_en_r <= 1'b0;
          error_r   <= 1'b1;
        end
      end else begin
        inst_en_r <= 1'b0;
        error_r   <= 1'b0;
      end
    end
  end

  assign req0_ready = ready0_r;
  assign req1_ready = ready1_r;
  assign inst       = inst_r;
  assign inst_en    = inst_en_r;
  assign grant      = grant_r;
  assign error      = error_r;

endmodule

// File: tb/tb_regbank_p2_arbiter.sv
// Table-driven bench for regbank_p2_arbiter: round-robin instance plus a fixed-priority instance.
// Opcode encodings assumed: NOP=4'h0, LD0=4'h1, LD1=4'h2; 4'hF is illegal.
module tb_regbank_p2_arbiter;
  typedef struct {
    logic        v0;
    logic [11:0] i0;
    logic        v1;
    logic [11:0] i1;
    logic        l0;
    logic        l1;
    logic [11:0] e_inst;
    logic        e_en;
    logic        e_grant;
    logic        e_err;
    logic        e_r0;
    logic        e_r1;
    logic        e_gfix;
  } vec_t;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] req0_inst, req1_inst;
  logic        req0_valid, req1_valid, req0_lock, req1_lock;
  logic        req0_ready, req1_ready;
  logic [11:0] inst;
  logic        inst_en, grant, error;
  logic        f_req0_ready, f_req1_ready;
  logic [11:0] f_inst;
  logic        f_inst_en, f_grant, f_error;

  vec_t vecs [17];
  int   checks = 0;
  int   errors = 0;

  always #5 clock = ~clock;

  regbank_p2_arbiter #(.PRIO_FIX(1'b0)) dut (
    .clock(clock), .reset(reset),
    .req0_inst(req0_inst), .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_lock(req0_lock),
    .req1_inst(req1_inst), .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_lock(req1_lock),
    .inst(inst), .inst_en(inst_en), .grant(grant), .error(error)
  );

  regbank_p2_arbiter #(.PRIO_FIX(1'b1)) dut_fix (
    .clock(clock), .reset(reset),
    .req0_inst(req0_inst), .req0_valid(req0_valid), .req0_ready(f_req0_ready), .req0_lock(req0_lock),
    .req1_inst(req1_inst), .req1_valid(req1_valid), .req1_ready(f_req1_ready), .req1_lock(req1_lock),
    .inst(f_inst), .inst_en(f_inst_en), .grant(f_grant), .error(f_error)
  );

  task automatic chk(input string name, input logic [11:0] act, input logic [11:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v0, input logic [11:0] i0, input logic v1, input logic [11:0] i1,
                       input logic l0, input logic l1);
    @(negedge clock);
    req0_valid = v0; req0_inst = i0; req1_valid = v1; req1_inst = i1;
    req0_lock  = l0; req1_lock = l1;
    @(posedge clock);
    #1;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[1]  = '{1'b1, 12'h1BA, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 12'h1BA, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 12'h1BA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 12'h000, 1'b1, 12'hFAB, 1'b0, 1'b0, 12'h1BA, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[5]  = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 12'h1BA, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    vecs[6]  = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 12'h1BA, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
    vecs[7]  = '{1'b1, 12'h111, 1'b1, 12'h222, 1'b0, 1'b0, 12'h1BA, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{1'b1, 12'h111, 1'b1, 12'h222, 1'b0, 1'b0, 12'h111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 12'h111, 1'b1, 12'h222, 1'b0, 1'b0, 12'h222, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[10] = '{1'b1, 12'h111, 1'b1, 12'h222, 1'b0, 1'b0, 12'h111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 12'h111, 1'b1, 12'h222, 1'b0, 1'b0, 12'h222, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    vecs[12] = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 12'h111, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 12'h111, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
    vecs[14] = '{1'b1, 12'h101, 1'b1, 12'h255, 1'b1, 1'b0, 12'h111, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
`ifdef REGBANK_P2_ARBITER_LOCK_EN
    vecs[15] = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b1, 1'b0, 12'h101, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vecs[16] = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 12'h255, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
`else
    vecs[15] = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b1, 1'b0, 12'h255, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[16] = '{1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, 12'h101, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`endif

    reset = 1'b0;
    req0_valid = 1'b0; req0_inst = 12'h000; req0_lock = 1'b0;
    req1_valid = 1'b0; req1_inst = 12'h000; req1_lock = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    chk("rst inst", inst, 12'h000);
    chk("rst inst_en", {11'd0, inst_en}, 12'h000);
    chk("rst grant", {11'd0, grant}, 12'h000);
    chk("rst error", {11'd0, error}, 12'h000);
    chk("rst ready0", {11'd0, req0_ready}, 12'h000);
    chk("rst ready1", {11'd0, req1_ready}, 12'h000);
    chk("rst fix ready0", {11'd0, f_req0_ready}, 12'h000);
    @(negedge clock);
    reset = 1'b1;

    for (int k = 0; k < 17; k++) begin
      drive(vecs[k].v0, vecs[k].i0, vecs[k].v1, vecs[k].i1, vecs[k].l0, vecs[k].l1);
      chk($sformatf("s%0d inst", k + 1), inst, vecs[k].e_inst);
      chk($sformatf("s%0d inst_en", k + 1), {11'd0, inst_en}, {11'd0, vecs[k].e_en});
      chk($sformatf("s%0d grant", k + 1), {11'd0, grant}, {11'd0, vecs[k].e_grant});
      chk($sformatf("s%0d error", k + 1), {11'd0, error}, {11'd0, vecs[k].e_err});
      chk($sformatf("s%0d ready0", k + 1), {11'd0, req0_ready}, {11'd0, vecs[k].e_r0});
      chk($sformatf("s%0d ready1", k + 1), {11'd0, req1_ready}, {11'd0, vecs[k].e_r1});
      chk($sformatf("s%0d fix grant", k + 1), {11'd0, f_grant}, {11'd0, vecs[k].e_gfix});
    end

    // Reset mid-operation: issue in flight and hold1 full when reset hits.
    drive(1'b1, 12'h133, 1'b0, 12'h000, 1'b0, 1'b0);
    chk("mid ready0", {11'd0, req0_ready}, 12'h000);
    drive(1'b0, 12'h000, 1'b1, 12'h244, 1'b0, 1'b0);
    chk("mid inst", inst, 12'h133);
    chk("mid inst_en", {11'd0, inst_en}, 12'h001);
    chk("mid ready1", {11'd0, req1_ready}, 12'h000);
    #2 reset = 1'b0;
    #1;
    chk("async inst_en", {11'd0, inst_en}, 12'h000);
    chk("async error", {11'd0, error}, 12'h000);
    chk("async inst", inst, 12'h000);
    chk("async ready1", {11'd0, req1_ready}, 12'h000);
    @(negedge clock);
    req1_valid = 1'b0;
    reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0);
      chk($sformatf("post%0d inst_en", k), {11'd0, inst_en}, 12'h000);
      chk($sformatf("post%0d error", k), {11'd0, error}, 12'h000);
    end
    chk("post ready1", {11'd0, req1_ready}, 12'h001);
    drive(1'b0, 12'h000, 1'b1, 12'h077, 1'b0, 1'b0);
    chk("fresh accept inst_en", {11'd0, inst_en}, 12'h000);
    drive(1'b0, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0);
    chk("fresh nop inst", inst, 12'h077);
    chk("fresh nop inst_en", {11'd0, inst_en}, 12'h001);
    chk("fresh nop grant", {11'd0, grant}, 12'h001);
    chk("fresh nop error", {11'd0, error}, 12'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
